// File: rtl/aes_enc_loader_if.sv
// Write bus into the AES loader: one 32-bit beat per accepted valid/ready handshake.
interface aes_enc_loader_if #(
  parameter int WORD_W = 32
);
  logic              s_wvalid;
  logic [2:0]        s_waddr;
  logic [WORD_W-1:0] s_wdata;
  logic              s_wready;

  modport master (output s_wvalid, s_waddr, s_wdata, input s_wready);
  modport slave  (input s_wvalid, s_waddr, s_wdata, output s_wready);
endinterface

// File: rtl/aes_enc_loader.sv
// Stages four data words plus flags from the write bus, then issues a control phase and a
// data phase to the AES encryptor and holds the block for the encryption latency.
module aes_enc_loader #(
  parameter int N          = 16,
  parameter int NFLAGS     = 8,
  parameter int WORD_W     = 32,
  parameter int CTRL_HOLD  = 2,
  parameter int DATA_HOLD  = 2,
  parameter int LAT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  aes_enc_loader_if.slave    s_w,
  output logic               addr,
  output logic [N*8-1:0]     plaintext,
  output logic [NFLAGS-1:0]  flags,
  output logic               busy,
  output logic               blk_done,
  output logic               err_addr
);
  localparam int MAXH = (CTRL_HOLD > DATA_HOLD) ?
                        ((CTRL_HOLD > LAT_CYCLES) ? CTRL_HOLD : LAT_CYCLES) :
                        ((DATA_HOLD > LAT_CYCLES) ? DATA_HOLD : LAT_CYCLES);
  localparam int CW = $clog2(MAXH) + 1;

  typedef enum logic [1:0] {IDLE, CTRL, DATA, WAIT} st_t;

  st_t                     r_state, w_nxt;
  logic [CW-1:0]           r_cnt;
  logic [3:0][WORD_W-1:0]  r_stage;
  logic [3:0]              r_wmask;
  logic [NFLAGS-1:0]       r_fstage, r_flg_q;
  logic [N*8-1:0]          r_blk_q;

  logic                    w_accept, w_word, w_flagw, w_ill, w_last, w_commit;
  logic [NFLAGS-1:0]       w_flg_nxt;
  logic [N*8-1:0]          w_blk_nxt;
  logic                    w_addr, w_busy;
  logic [N*8-1:0]          w_pt;
  logic [NFLAGS-1:0]       w_flags;

  assign s_w.s_wready = !(r_wmask == 4'hF && r_state != IDLE);
  assign w_accept = s_w.s_wvalid && s_w.s_wready;
  assign w_word   = w_accept && !s_w.s_waddr[2];
  assign w_flagw  = w_accept && (s_w.s_waddr == 3'd4);
  assign w_ill    = w_accept && (s_w.s_waddr > 3'd4);
  assign w_last   = (r_cnt == CW'(1));
  // A full block commits from IDLE or straight out of the last WAIT cycle.
  assign w_commit = (r_wmask == 4'hF) &&
                    (r_state == IDLE || (r_state == WAIT && w_last));

  assign w_flg_nxt = w_commit ? r_fstage : r_flg_q;
  assign w_blk_nxt = w_commit ? r_stage  : r_blk_q;

  // State register and hold counter, reloaded on every state entry
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        unique case (w_nxt)
          CTRL:    r_cnt <= CW'(CTRL_HOLD);
          DATA:    r_cnt <= CW'(DATA_HOLD);
          WAIT:    r_cnt <= CW'(LAT_CYCLES);
          default: r_cnt <= '0;
        endcase
      end else if (r_cnt > CW'(1)) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_commit) w_nxt = CTRL;
      CTRL:    if (w_last)   w_nxt = DATA;
      DATA:    if (w_last)   w_nxt = WAIT;
      WAIT:    if (w_last)   w_nxt = w_commit ? CTRL : IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Output values for the next state; registered below so every output comes from a flop
  always_comb begin
    w_addr  = 1'b0;
    w_pt    = '0;
    w_flags = '0;
    w_busy  = 1'b0;
    unique case (w_nxt)
      CTRL: begin
        w_pt    = {{(N*8-NFLAGS){1'b0}}, w_flg_nxt};
        w_flags = w_flg_nxt;
        w_busy  = 1'b1;
      end
      DATA, WAIT: begin
        w_addr  = 1'b1;
        w_pt    = w_blk_nxt;
        w_flags = w_flg_nxt;
        w_busy  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= 1'b0;
      plaintext <= '0;
      flags     <= '0;
      busy      <= 1'b0;
      blk_done  <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      addr      <= w_addr;
      plaintext <= w_pt;
      flags     <= w_flags;
      busy      <= w_busy;
      blk_done  <= (r_state == WAIT) && w_last;
      err_addr  <= w_ill;
    end
  end

  // Staging; a beat on the commit edge lands in the fresh mask and belongs to the next block
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage  <= '0;
      r_wmask  <= '0;
      r_fstage <= '0;
      r_flg_q  <= '0;
      r_blk_q  <= '0;
    end else begin
      if (w_word)  r_stage[s_w.s_waddr[1:0]] <= s_w.s_wdata;
      if (w_flagw) r_fstage <= s_w.s_wdata[NFLAGS-1:0];
      if (w_commit) begin
        r_blk_q <= r_stage;
        r_flg_q <= r_fstage;
        r_wmask <= w_word ? (4'b0001 << s_w.s_waddr[1:0]) : 4'b0000;
      end else if (w_word) begin
        r_wmask[s_w.s_waddr[1:0]] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_aes_enc_loader.sv
// Directed bench: stimulus pushes expected blocks into a queue, a monitor pops them as blocks issue.
module tb_aes_enc_loader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_enc_loader_if #(.WORD_W(32)) bus();
  logic         addr, busy, done, err;
  logic [127:0] pt;
  logic [7:0]   flg;

  aes_enc_loader dut (
    .clk(clk), .reset(rst), .s_w(bus), .addr(addr), .plaintext(pt),
    .flags(flg), .busy(busy), .blk_done(done), .err_addr(err)
  );

  typedef struct {
    logic [7:0]   f;
    logic [127:0] b;
    bit           abort;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0, done_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // Monitor: pops one expectation per block entering CTRL
  exp_t cur;
  bit   in_blk = 0;
  int   cyc = 0;
  logic pbusy = 1'b0, paddr = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (in_blk) chk("abort_expected", 128'(cur.abort), 128'(1));
      in_blk = 0; pbusy = 1'b0; paddr = 1'b0;
    end else begin
      if (in_blk) cyc++;
      if (done) begin
        done_cnt++;
        if (!in_blk) chk("done_without_block", 128'(in_blk), 128'(1));
        else begin
          chk("latency", 128'(cyc), 128'(68));
          chk("done_not_aborted", 128'(cur.abort), 128'(0));
          in_blk = 0;
        end
      end
      if (in_blk && cyc == 1) chk("ctrl_hold_addr", 128'(addr), 128'(0));
      if (in_blk && cyc == 2) begin
        chk("data_addr", 128'(addr), 128'(1));
        chk("data_pt", pt, cur.b);
        chk("data_flags", 128'(flg), 128'(cur.f));
      end
      if (busy && !addr && (!pbusy || paddr)) begin
        if (q.size() == 0) chk("unexpected_block", 128'(q.size()), 128'(1));
        else begin
          cur = q.pop_front();
          in_blk = 1; cyc = 0;
          chk("ctrl_pt", pt, {120'b0, cur.f});
          chk("ctrl_flags", 128'(flg), 128'(cur.f));
        end
      end
      pbusy = busy; paddr = addr;
    end
  end

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    int n = 0;
    bus.s_wvalid = 1'b1; bus.s_waddr = a; bus.s_wdata = d;
    while (!bus.s_wready && n < 300) begin @(negedge clk); n++; end
    if (!bus.s_wready) chk("wready_timeout", 128'(bus.s_wready), 128'(1));
    @(negedge clk);
    bus.s_wvalid = 1'b0;
  endtask

  task automatic blk(input logic [7:0] f, input logic [127:0] b, input bit ab);
    exp_t e;
    e.f = f; e.b = b; e.abort = ab;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) q.push_back(e);
      wr(3'(k), b[32*k +: 32]);
    end
  endtask

  task automatic wait_done(input int k);
    int n = 0;
    while (done_cnt < k && n < 400) begin @(negedge clk); n++; end
    if (done_cnt < k) chk("done_timeout", 128'(done_cnt), 128'(k));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int d0;
    bit dropped;
    exp_t e;
    // T1: reset with a live beat on the bus
    rst = 1'b1;
    bus.s_wvalid = 1'b1; bus.s_waddr = 3'd0; bus.s_wdata = 32'hDEAD_BEEF;
    idle(2);
    chk("rst_addr", 128'(addr), 128'(0));
    chk("rst_pt", pt, 128'(0));
    chk("rst_flags", 128'(flg), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_wready", 128'(bus.s_wready), 128'(1));
    bus.s_wvalid = 1'b0;
    rst = 1'b0;
    idle(2);

    // T2: single block
    wr(3'd4, 32'h01);
    blk(8'h01, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 1'b0);
    wait_done(1);
    idle(1);
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_flags", 128'(flg), 128'(0));
    idle(2);

    // T3: block B written while A is in flight
    blk(8'h01, 128'h44444444_33333333_22222222_11111111, 1'b0);
    d0 = done_cnt;
    idle(10);
    blk(8'h01, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 1'b0);
    chk("wready_drop", 128'(bus.s_wready), 128'(0));
    dropped = 0;
    for (int n = 0; n < 400 && done_cnt < d0 + 2; n++) begin
      if (!busy) dropped = 1;
      @(negedge clk);
    end
    chk("busy_gap", 128'(dropped), 128'(0));
    wait_done(3);
    idle(2);

    // T4: overwrite word 2 and illegal-address beats
    wr(3'd0, 32'h0000_1111);
    wr(3'd1, 32'h0000_2222);
    wr(3'd2, 32'h0000_AAAA);
    wr(3'd6, 32'hFFFF_FFFF);
    chk("err_pulse6", 128'(err), 128'(1));
    idle(1);
    chk("err_once", 128'(err), 128'(0));
    wr(3'd7, 32'hFFFF_FFFF);
    chk("err_pulse7", 128'(err), 128'(1));
    wr(3'd2, 32'h0000_5555);
    chk("err_clear", 128'(err), 128'(0));
    idle(1);
    chk("mask_untouched", 128'(busy), 128'(0));
    e.f = 8'h01; e.b = 128'h00003333_00005555_00002222_00001111; e.abort = 1'b0;
    q.push_back(e);
    wr(3'd3, 32'h0000_3333);
    wait_done(4);
    idle(2);

    // T5: reset on the 10th WAIT cycle aborts the block
    blk(8'h01, 128'h9999_8888_7777_6666_5555_4444_3333_2222, 1'b1);
    idle(14);
    d0 = done_cnt;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_addr", 128'(addr), 128'(0));
    chk("abort_pt", pt, 128'(0));
    chk("abort_flags", 128'(flg), 128'(0));
    idle(80);
    chk("no_done_after_abort", 128'(done_cnt), 128'(d0));
    blk(8'h00, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b0);
    wait_done(5);
    idle(2);

    // T6: flags beat on the commit edge applies to the following block
    wr(3'd4, 32'h01);
    blk(8'h01, 128'hA3A2A1A0_B3B2B1B0_C3C2C1C0_D3D2D1D0, 1'b0);
    wr(3'd4, 32'h03);
    blk(8'h03, 128'h01010101_02020202_03030303_04040404, 1'b0);
    wait_done(7);
    idle(5);
    chk("queue_drained", 128'(q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
